// File: rtl/lutram_dp_tester.sv
// Self-checking sweep of an inferred dual-port LUTRAM: clear, write pattern, read both ports, report.
// Define LUTRAM_TESTER_CONTINUOUS_EN to repeat sweeps forever with the pattern inverted on alternate sweeps.
module lutram_dp_tester #(
  parameter int unsigned          A_WIDTH         = 5,
  parameter int unsigned          D_WIDTH         = 4,
  parameter logic [31:0]          DIV_COUNTER_END = 32'h00FF_FFFF,
  parameter int unsigned          DPRA_OFFSET     = 1,
  parameter logic [D_WIDTH-1:0]   SEED            = '0,
  parameter int unsigned          ERR_WIDTH       = 8
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  output logic [2*D_WIDTH-1:0]   q_o,
  output logic                   done_o,
  output logic                   pass_o,
  output logic [ERR_WIDTH-1:0]   err_count_o,
  output logic [7:0]             pass_count_o
);
  localparam int unsigned DEPTH = 1 << A_WIDTH;
  localparam logic [A_WIDTH-1:0] OFFSET = A_WIDTH'(DPRA_OFFSET % DEPTH);

  typedef enum logic [2:0] {
    S_INIT   = 3'd0,
    S_CLEAR  = 3'd1,
    S_WRITE  = 3'd2,
    S_READ   = 3'd3,
    S_FINISH = 3'd4
  } state_t;

  state_t               state_q, state_d;
  logic [A_WIDTH-1:0]   addr_q, addr_d, dpra;
  logic [31:0]          div_counter;
  logic                 tick, we, last, phase;
  logic [D_WIDTH-1:0]   mem [DEPTH];
  logic [D_WIDTH-1:0]   wdata, spo, dpo;
  logic                 miss_spo, miss_dpo;
  logic [ERR_WIDTH-1:0] err_next;

  function automatic logic [D_WIDTH-1:0] pat(input logic [A_WIDTH-1:0] a, input logic ph);
    logic [D_WIDTH-1:0] v;
    v = D_WIDTH'(a);
    return (v + SEED) ^ {D_WIDTH{ph}};
  endfunction

  function automatic logic [ERR_WIDTH-1:0] sat_add(input logic [ERR_WIDTH-1:0] c,
                                                   input logic [1:0] inc);
    logic [ERR_WIDTH:0] s;
    s = {1'b0, c} + (ERR_WIDTH+1)'(inc);
    return s[ERR_WIDTH] ? '1 : s[ERR_WIDTH-1:0];
  endfunction

  // Step-tick generator
  assign tick = (div_counter == DIV_COUNTER_END);

  always_ff @(posedge clk_i) begin
    if (rst_i || tick) div_counter <= '0;
    else               div_counter <= div_counter + 32'd1;
  end

  // RAM under test: synchronous write, asynchronous reads on both ports
  assign last  = (addr_q == '1);
  assign dpra  = addr_q + OFFSET;
  assign wdata = (state_q == S_WRITE) ? pat(addr_q, phase) : '0;
  assign we    = tick && !rst_i && (state_q == S_CLEAR || state_q == S_WRITE);
  assign spo   = mem[addr_q];
  assign dpo   = mem[dpra];

  always_ff @(posedge clk_i) begin
    if (we) mem[addr_q] <= wdata;
  end

  assign miss_spo = (spo != pat(addr_q, phase));
  assign miss_dpo = (dpo != pat(dpra, phase));
  assign err_next = sat_add(err_count_o, {1'b0, miss_spo} + {1'b0, miss_dpo});

  // Sequencer
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= S_INIT;
      addr_q  <= '0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
    end
  end

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    if (tick) begin
      case (state_q)
        S_INIT: begin
          state_d = S_CLEAR;
          addr_d  = '0;
        end
        S_CLEAR: begin
          addr_d = addr_q + 1'b1;
          if (last) state_d = S_WRITE;
        end
        S_WRITE: begin
          addr_d = addr_q + 1'b1;
          if (last) state_d = S_READ;
        end
        S_READ: begin
          addr_d = addr_q + 1'b1;
          if (last) state_d = S_FINISH;
        end
        S_FINISH: begin
`ifdef LUTRAM_TESTER_CONTINUOUS_EN
          state_d = S_CLEAR;
`else
          state_d = S_FINISH;
`endif
          addr_d  = '0;
        end
        default: begin
          state_d = S_INIT;
          addr_d  = '0;
        end
      endcase
    end
  end

  // Result registers: capture read data and tally mismatches on READ ticks
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      q_o          <= '0;
      done_o       <= 1'b0;
      pass_o       <= 1'b0;
      err_count_o  <= '0;
      pass_count_o <= '0;
      phase        <= 1'b0;
    end else if (tick) begin
      if (state_q == S_READ) begin
        q_o         <= {dpo, spo};
        err_count_o <= err_next;
        if (last) begin
          done_o <= 1'b1;
          pass_o <= (err_next == '0);
        end
      end
`ifdef LUTRAM_TESTER_CONTINUOUS_EN
      if (state_q == S_FINISH) begin
        done_o       <= 1'b0;
        phase        <= ~phase;
        pass_count_o <= pass_count_o + 8'd1;
      end
`endif
    end
  end

endmodule

// File: tb/tb_lutram_dp_tester.sv
// Scoreboard bench for lutram_dp_tester: a bench-side RAM model predicts every READ-tick q_o.
module tb_lutram_dp_tester;
  localparam int AW = 5;
  localparam int DW = 4;
  localparam int DEPTH = 32;
  localparam int OFF = 1;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic [2*DW-1:0] q, q2;
  logic            done, pass, done2, pass2;
  logic [7:0]      err, pcnt, pcnt2;
  logic [1:0]      err2;

  lutram_dp_tester #(.A_WIDTH(AW), .D_WIDTH(DW), .DIV_COUNTER_END(32'd3),
                     .DPRA_OFFSET(OFF), .SEED('0), .ERR_WIDTH(8)) dut (
    .clk_i(clk), .rst_i(rst), .q_o(q), .done_o(done), .pass_o(pass),
    .err_count_o(err), .pass_count_o(pcnt));

  lutram_dp_tester #(.A_WIDTH(AW), .D_WIDTH(DW), .DIV_COUNTER_END(32'd3),
                     .DPRA_OFFSET(OFF), .SEED('0), .ERR_WIDTH(2)) dut2 (
    .clk_i(clk), .rst_i(rst), .q_o(q2), .done_o(done2), .pass_o(pass2),
    .err_count_o(err2), .pass_count_o(pcnt2));

  int n_chk = 0;
  int n_bad = 0;
  int pc = 0;
  logic [DW-1:0]   mem_m [DEPTH];
  logic [DW-1:0]   force_val;
  logic [2*DW-1:0] exp_q [$];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [DW-1:0] pat(input int a, input bit ph);
    logic [DW-1:0] v;
    v = DW'(a);
    return v ^ {DW{ph}};
  endfunction

  task automatic do_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    pc = 0;
  endtask

  task automatic check_zero(input string tag);
    chk({tag, "_q"}, 32'(q), 0);
    chk({tag, "_done"}, 32'(done), 0);
    chk({tag, "_pass"}, 32'(pass), 0);
    chk({tag, "_err"}, 32'(err), 0);
    chk({tag, "_pcnt"}, 32'(pcnt), 0);
  endtask

  // base: tick index that enters CLEAR (the INITIAL or FINISH tick); sweep ends 97 ticks later
  task automatic sweep(input int base, input int fault_a, input int abort_a, input bit ph,
                       input int exp_err, input bit exp_pass);
    int n, k, a, rd_a, end_p;
    bit rd, forced;
    logic [DW-1:0] fv;
    logic [2*DW-1:0] e;
    end_p = 4 * (base + 97);
    while (pc < end_p) begin
      rd = 1'b0;
      forced = 1'b0;
      rd_a = 0;
      if ((pc + 1) % 4 == 0) begin
        n = (pc + 1) / 4 - 1;
        if (n > base) begin
          k = n - base - 1;
          a = k % DEPTH;
          if (k < 32) begin
            mem_m[a] = '0;
          end else if (k < 64) begin
            fv = pat(a, ph);
            if (a == fault_a) begin
              fv[0] = ~fv[0];
              force_val = fv;
              force dut.wdata = force_val;
              forced = 1'b1;
            end
            mem_m[a] = fv;
          end else begin
            exp_q.push_back({mem_m[(a + OFF) % DEPTH], mem_m[a]});
            rd = 1'b1;
            rd_a = a;
          end
        end
      end
      @(posedge clk);
      #1;
      pc++;
      if (forced) release dut.wdata;
      if (rd) begin
        e = exp_q.pop_front();
        chk($sformatf("q_a%0d", rd_a), 32'(q), 32'(e));
        if (rd_a == 5) chk("q_a5_const", 32'(q), ph ? 32'h9A : 32'h65);
        if (rd_a == 31 && !ph) chk("q_a31_const", 32'(q), 32'h0F);
        if (rd_a == abort_a) begin
          rst = 1'b1;
          @(posedge clk);
          #1;
          check_zero("abort");
          rst = 1'b0;
          pc = 0;
          return;
        end
      end
      if (base > 0 && pc == 4 * (base + 1)) begin
        chk("restart_done", 32'(done), 0);
        chk("restart_pcnt", 32'(pcnt), 1);
        chk("restart_pass_hold", 32'(pass), 1);
      end
      if (pc == end_p - 1) chk("done_early", 32'(done), 0);
    end
    chk("done", 32'(done), 1);
    chk("pass", 32'(pass), 32'(exp_pass));
    chk("err", 32'(err), 32'(exp_err));
  endtask

  initial begin
    int miss;
    force dut2.wdata = 4'hF;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check_zero("reset");
    do_reset();

    sweep(0, -1, -1, 1'b0, 0, 1'b1);
    chk("sat_err", 32'(err2), 3);
    chk("sat_pass", 32'(pass2), 0);
    chk("sat_done", 32'(done2), 1);

`ifdef LUTRAM_TESTER_CONTINUOUS_EN
    sweep(97, -1, -1, 1'b1, 0, 1'b1);
    repeat (4) @(posedge clk);
    #1;
    chk("cont_pcnt2", 32'(pcnt), 2);
    chk("cont_err", 32'(err), 0);
    chk("sat_err_hold", 32'(err2), 3);
`else
    miss = 0;
    for (int i = 0; i < 1000; i++) begin
      @(posedge clk);
      #1;
      if (done !== 1'b1) miss++;
    end
    chk("done_hold_miss", 32'(miss), 0);
    chk("pcnt_zero", 32'(pcnt), 0);
    chk("sat_err_hold", 32'(err2), 3);
`endif

    do_reset();
    sweep(0, -1, 10, 1'b0, 0, 1'b1);
    sweep(0, 7, -1, 1'b0, 2, 1'b0);

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end
endmodule
